instr_fetch_core: RTL and testbench

//  Fetch/decode/execute engine that drives the Program_Rom address port and consumes its 14-bit words.

---
 rtl/instr_fetch_core.sv | 134 +++++++++++++
 tb/tb_instr_fetch_core.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_core.sv
// Two-state fetch/execute core for the literal instruction subset plus NOP and GOTO.
// Drives the program ROM address from PC and executes one instruction every two cycles.
module instr_fetch_core #(
    parameter logic [10:0] RESET_VECTOR = 11'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [10:0] Rom_addr_out,
    input  logic [13:0] Rom_data_in,
    output logic [7:0]  W_out,
    output logic [7:0]  X_out,
    output logic        Z_out,
    output logic        C_out,
    output logic        retire,
    output logic        illegal
);

    typedef enum logic {
        FETCH   = 1'b0,
        EXECUTE = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [10:0] pc, pc_next;
    logic [13:0] ir, ir_next;
    logic [7:0]  w, w_next;
    logic [7:0]  x, x_next;
    logic        z, z_next;
    logic        c, c_next;
    logic        retire_next;
    logic        illegal_next;
    logic [5:0]  opcode;
    logic [7:0]  k;
    logic [8:0]  sum;
    logic [7:0]  conj;

    function automatic logic [8:0] add9(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign opcode = ir[13:8];
    assign k      = ir[7:0];

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        ir_next      = ir;
        w_next       = w;
        x_next       = x;
        z_next       = z;
        c_next       = c;
        retire_next  = 1'b0;
        illegal_next = 1'b0;
        sum          = 9'h000;
        conj         = 8'h00;

        case (state)
            FETCH: begin
                if (run) begin
                    ir_next    = Rom_data_in;
                    state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                state_next  = FETCH;
                retire_next = 1'b1;
                pc_next     = pc + 11'd1;
                // Decode priority is significant: literal ops first, then NOP, then GOTO.
                if (opcode == 6'h30) begin
                    w_next = k;
                end else if (opcode == 6'h3E || opcode == 6'h3F) begin
                    sum    = add9(w, k);
                    w_next = sum[7:0];
                    c_next = sum[8];
                    z_next = (sum[7:0] == 8'h00);
                end else if (opcode == 6'h39) begin
                    conj   = w & k;
                    w_next = conj;
                    z_next = (conj == 8'h00);
                end else if (opcode == 6'h37) begin
                    x_next = k;
                end else if (opcode == 6'h01) begin
                    sum    = add9(x, k);
                    w_next = sum[7:0];
                    c_next = sum[8];
                    z_next = (sum[7:0] == 8'h00);
                end else if (opcode == 6'h02) begin
                    conj   = x & k;
                    w_next = conj;
                    z_next = (conj == 8'h00);
                end else if (ir == 14'h0000) begin
                    pc_next = pc + 11'd1;
                end else if (ir[13:11] == 3'b101) begin
                    pc_next = ir[10:0];
                end else begin
                    illegal_next = 1'b1;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_VECTOR;
            ir      <= 14'h0000;
            w       <= 8'h00;
            x       <= 8'h00;
            z       <= 1'b0;
            c       <= 1'b0;
            retire  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            ir      <= ir_next;
            w       <= w_next;
            x       <= x_next;
            z       <= z_next;
            c       <= c_next;
            retire  <= retire_next;
            illegal <= illegal_next;
        end
    end

    assign Rom_addr_out = pc;
    assign W_out        = w;
    assign X_out        = x;
    assign Z_out        = z;
    assign C_out        = c;

endmodule

// File: tb/tb_instr_fetch_core.sv
// Directed bench for instr_fetch_core with a behavioural combinational ROM.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_instr_fetch_core;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [10:0] Rom_addr_out;
    logic [13:0] Rom_data_in;
    logic [7:0]  W_out;
    logic [7:0]  X_out;
    logic        Z_out;
    logic        C_out;
    logic        retire;
    logic        illegal;

    logic [13:0] rom [0:2047];
    int          n_cmp;
    int          n_err;

    instr_fetch_core #(.RESET_VECTOR(11'h000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .Rom_addr_out (Rom_addr_out),
        .Rom_data_in  (Rom_data_in),
        .W_out        (W_out),
        .X_out        (X_out),
        .Z_out        (Z_out),
        .C_out        (C_out),
        .retire       (retire),
        .illegal      (illegal)
    );

    assign Rom_data_in = rom[Rom_addr_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
    endtask

    task automatic apply_reset(input logic run_val);
        rst_n = 1'b0;
        run   = run_val;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_retire(input string tag);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (retire !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (retire !== 1'b1) chk({tag, "_timeout"}, 32'(retire), 32'd1);
    endtask

    logic [7:0] exp_w1 [0:7];
    int         pulses;

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        run    = 1'b0;
        clear_rom();

        // Program image for the running-sum sequence
        rom[0] = 14'h300D;   // MOVLW 0D
        rom[1] = 14'h3EF5;   // ADDLW F5 -> 02, C=1
        rom[2] = 14'h3E02;   // ADDLW 02 -> 04, C=0
        rom[3] = 14'h3706;   // MOVLX 06
        rom[4] = 14'h3E07;   // ADDLW 07 -> 0B
        rom[5] = 14'h3903;   // ANDLW 03 -> 03
        rom[6] = 14'h0100;   // ADDLXW 00 -> 06
        rom[7] = 14'h02FF;   // ANDLXW FF -> 06
        exp_w1[0] = 8'h0D; exp_w1[1] = 8'h02; exp_w1[2] = 8'h04; exp_w1[3] = 8'h04;
        exp_w1[4] = 8'h0B; exp_w1[5] = 8'h03; exp_w1[6] = 8'h06; exp_w1[7] = 8'h06;

        apply_reset(1'b1);
        chk("rst_pc", 32'(Rom_addr_out), 32'h000);
        chk("rst_w", 32'(W_out), 32'h00);
        chk("rst_x", 32'(X_out), 32'h00);
        chk("rst_zc", 32'({Z_out, C_out}), 32'd0);
        chk("rst_pulses", 32'({retire, illegal}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            wait_retire("t1");
            chk($sformatf("t1_w%0d", i), 32'(W_out), 32'(exp_w1[i]));
        end
        chk("t1_x", 32'(X_out), 32'h06);
        chk("t1_pc", 32'(Rom_addr_out), 32'h008);
        chk("t1_z", 32'(Z_out), 32'd0);
        chk("t1_c", 32'(C_out), 32'd0);

        // Carry and zero from an 8-bit overflow; AND keeps C
        clear_rom();
        rom[0] = 14'h30FF;
        rom[1] = 14'h3E01;
        rom[2] = 14'h3900;
        apply_reset(1'b1);
        wait_retire("t2a");
        chk("t2_w_ff", 32'(W_out), 32'hFF);
        wait_retire("t2b");
        chk("t2_w_sum", 32'(W_out), 32'h00);
        chk("t2_c_sum", 32'(C_out), 32'd1);
        chk("t2_z_sum", 32'(Z_out), 32'd1);
        wait_retire("t2c");
        chk("t2_z_and", 32'(Z_out), 32'd1);
        chk("t2_c_and", 32'(C_out), 32'd1);

        // GOTO to the top of the address space, then wrap
        clear_rom();
        rom[0]     = 14'h2FFF;
        rom[11'h7FF] = 14'h0000;
        apply_reset(1'b1);
        wait_retire("t3a");
        chk("t3_goto_pc", 32'(Rom_addr_out), 32'h7FF);
        chk("t3_goto_ill", 32'(illegal), 32'd0);
        wait_retire("t3b");
        chk("t3_wrap_pc", 32'(Rom_addr_out), 32'h000);
        chk("t3_nop_ill", 32'(illegal), 32'd0);

        // Undecoded opcode retires as NOP with illegal
        clear_rom();
        rom[0] = 14'h30FF;
        rom[1] = 14'h3E01;
        rom[2] = 14'h3712;
        rom[3] = 14'h0700;
        apply_reset(1'b1);
        repeat (3) wait_retire("t4a");
        chk("t4_legal_ill", 32'(illegal), 32'd0);
        wait_retire("t4b");
        chk("t4_ill", 32'(illegal), 32'd1);
        chk("t4_ret", 32'(retire), 32'd1);
        chk("t4_w", 32'(W_out), 32'h00);
        chk("t4_x", 32'(X_out), 32'h12);
        chk("t4_zc", 32'({Z_out, C_out}), 32'b11);
        chk("t4_pc", 32'(Rom_addr_out), 32'h004);
        @(negedge clk);
        chk("t4_ill_clear", 32'(illegal), 32'd0);

        // run dropped during EXECUTE still completes that instruction
        clear_rom();
        rom[0] = 14'h3005;
        rom[1] = 14'h3007;
        apply_reset(1'b1);
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        wait_retire("t5a");
        chk("t5_w", 32'(W_out), 32'h05);
        chk("t5_pc", 32'(Rom_addr_out), 32'h001);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (retire === 1'b1) pulses++;
        end
        chk("t5_paused_retires", 32'(pulses), 32'd0);
        chk("t5_pc_hold", 32'(Rom_addr_out), 32'h001);
        run = 1'b1;
        wait_retire("t5b");
        chk("t5_resume_w", 32'(W_out), 32'h07);
        chk("t5_resume_pc", 32'(Rom_addr_out), 32'h002);

        // Asynchronous reset in the middle of EXECUTE
        clear_rom();
        rom[0] = 14'h3033;
        rom[1] = 14'h3E10;
        apply_reset(1'b1);
        wait_retire("t6a");
        chk("t6_w_pre", 32'(W_out), 32'h33);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_w_rst", 32'(W_out), 32'h00);
        chk("t6_pc_rst", 32'(Rom_addr_out), 32'h000);
        chk("t6_ret_rst", 32'(retire), 32'd0);
        @(negedge clk);
        chk("t6_ret_hold", 32'(retire), 32'd0);
        chk("t6_w_hold", 32'(W_out), 32'h00);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
